// File: rtl/sw_req_gen.sv
// sw_req_gen: request side of the separable switch allocator for one input port.
// Tracks per-VC buffer occupancy, downstream credits and queued packet
// destinations, raises per-VC requests and turns first-stage grants into
// buffer reads and upstream credit returns.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   wr_en/wr_vc       flit written into the port buffer, one-hot VC
//   wr_hdr/wr_tail    flit type (both set = single-flit packet)
//   wr_port_sel       routed output select, sampled with a header write
//   credit_in         one-hot credit returned by the downstream router
//   in_vc_granted     one-hot same-cycle grant from the allocator
//   in_vc_requests    per-VC request (combinational)
//   port_selects      per-VC destination, VC i at [(i+1)*W-1:i*W] (combinational)
//   rd_vc             one-hot buffer read select (combinational)
//   credit_out        registered credit to the upstream router
//   err               sticky protocol-error flag
module sw_req_gen #(
  parameter int unsigned VC_NUM_PER_PORT    = 4,
  parameter int unsigned PORT_NUM           = 5,
  parameter int unsigned PORT_SEL_BCD_WIDTH = $clog2(PORT_NUM - 1),
  parameter int unsigned BUF_DEPTH          = 4,
  parameter int unsigned DST_FIFO_DEPTH     = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          wr_en,
  input  logic [VC_NUM_PER_PORT-1:0]                    wr_vc,
  input  logic                                          wr_hdr,
  input  logic                                          wr_tail,
  input  logic [PORT_SEL_BCD_WIDTH-1:0]                 wr_port_sel,
  input  logic [VC_NUM_PER_PORT-1:0]                    credit_in,
  input  logic [VC_NUM_PER_PORT-1:0]                    in_vc_granted,
  output logic [VC_NUM_PER_PORT-1:0]                    in_vc_requests,
  output logic [VC_NUM_PER_PORT*PORT_SEL_BCD_WIDTH-1:0] port_selects,
  output logic [VC_NUM_PER_PORT-1:0]                    rd_vc,
  output logic [VC_NUM_PER_PORT-1:0]                    credit_out,
  output logic                                          err
);

  localparam int unsigned VC_N   = VC_NUM_PER_PORT;
  localparam int unsigned SEL_W  = PORT_SEL_BCD_WIDTH;
  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W  = (DST_FIFO_DEPTH > 1) ? $clog2(DST_FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(DST_FIFO_DEPTH + 1);

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_e;

  vc_state_e        state_q   [VC_N];
  vc_state_e        state_d   [VC_N];
  logic [CNT_W-1:0] occ_q     [VC_N];
  logic [CNT_W-1:0] occ_d     [VC_N];
  logic [CNT_W-1:0] cred_q    [VC_N];
  logic [CNT_W-1:0] cred_d    [VC_N];
  // One tail marker per buffered flit, slot 0 = oldest flit
  logic [BUF_DEPTH-1:0] tail_q [VC_N];
  logic [BUF_DEPTH-1:0] tail_d [VC_N];
  logic [SEL_W-1:0] dst_q     [VC_N][DST_FIFO_DEPTH];
  logic [SEL_W-1:0] dst_d     [VC_N][DST_FIFO_DEPTH];
  logic [PTR_W-1:0] dst_rd_q  [VC_N];
  logic [PTR_W-1:0] dst_rd_d  [VC_N];
  logic [PTR_W-1:0] dst_wr_q  [VC_N];
  logic [PTR_W-1:0] dst_wr_d  [VC_N];
  logic [FCNT_W-1:0] dst_cnt_q [VC_N];
  logic [FCNT_W-1:0] dst_cnt_d [VC_N];

  logic [VC_N-1:0] credit_out_q, credit_out_d;
  logic            err_q, err_d;

  logic [VC_N-1:0] gnt_low;
  logic [VC_N-1:0] wr_hit;
  logic [VC_N-1:0] wr_ok;
  logic [VC_N-1:0] push_ok;
  logic [VC_N-1:0] tail_gnt;
  logic            multi_hot;
  logic            stray_gnt;

  assign credit_out = credit_out_q;
  assign err        = err_q;

  // Grant qualification: keep only the lowest grant bit, and only where requested
  always_comb begin
    gnt_low   = in_vc_granted & VC_N'(~in_vc_granted + VC_N'(1));
    multi_hot = (in_vc_granted & VC_N'(in_vc_granted - VC_N'(1))) != '0;
    stray_gnt = (in_vc_granted & ~in_vc_requests) != '0;
    rd_vc     = gnt_low & in_vc_requests;
  end

  // Per-VC counters, tail markers and destination FIFO update
  always_comb begin
    err_d        = err_q | multi_hot | stray_gnt;
    credit_out_d = rd_vc;
    wr_hit       = '0;
    wr_ok        = '0;
    push_ok      = '0;
    tail_gnt     = '0;
    for (int i = 0; i < VC_N; i++) begin
      occ_d[i]     = occ_q[i];
      cred_d[i]    = cred_q[i];
      tail_d[i]    = tail_q[i];
      dst_rd_d[i]  = dst_rd_q[i];
      dst_wr_d[i]  = dst_wr_q[i];
      dst_cnt_d[i] = dst_cnt_q[i];
      for (int k = 0; k < DST_FIFO_DEPTH; k++) begin
        dst_d[i][k] = dst_q[i][k];
      end

      wr_hit[i]   = wr_en & wr_vc[i];
      // A same-cycle read frees a slot, so a write to a full VC is still accepted then
      wr_ok[i]    = wr_hit[i] & (rd_vc[i] | (occ_q[i] != CNT_W'(BUF_DEPTH)));
      push_ok[i]  = wr_hit[i] & wr_hdr & (dst_cnt_q[i] != FCNT_W'(DST_FIFO_DEPTH));
      tail_gnt[i] = rd_vc[i] & tail_q[i][0];

      if (wr_hit[i] && !wr_ok[i]) begin
        err_d = 1'b1;
      end
      if (wr_hit[i] && wr_hdr && !push_ok[i]) begin
        err_d = 1'b1;
      end
      if (credit_in[i] && !rd_vc[i] && (cred_q[i] == CNT_W'(BUF_DEPTH))) begin
        err_d = 1'b1;
      end

      // Occupancy
      if (wr_ok[i] && !rd_vc[i]) begin
        occ_d[i] = occ_q[i] + CNT_W'(1);
      end else if (rd_vc[i] && !wr_hit[i]) begin
        occ_d[i] = occ_q[i] - CNT_W'(1);
      end

      // Downstream credits
      if (credit_in[i] && !rd_vc[i]) begin
        if (cred_q[i] != CNT_W'(BUF_DEPTH)) begin
          cred_d[i] = cred_q[i] + CNT_W'(1);
        end
      end else if (rd_vc[i] && !credit_in[i]) begin
        cred_d[i] = cred_q[i] - CNT_W'(1);
      end

      // Tail markers: shift out the read flit, append the written one behind the rest
      if (rd_vc[i]) begin
        tail_d[i] = tail_q[i] >> 1;
      end
      if (wr_ok[i]) begin
        for (int j = 0; j < BUF_DEPTH; j++) begin
          if (CNT_W'(j) == (rd_vc[i] ? occ_q[i] - CNT_W'(1) : occ_q[i])) begin
            tail_d[i][j] = wr_tail;
          end
        end
      end

      // Destination FIFO: push on header write, pop when the tail leaves
      if (push_ok[i]) begin
        dst_d[i][dst_wr_q[i]] = wr_port_sel;
        dst_wr_d[i]           = dst_wr_q[i] + PTR_W'(1);
      end
      if (tail_gnt[i]) begin
        dst_rd_d[i] = dst_rd_q[i] + PTR_W'(1);
      end
      if (push_ok[i] && !tail_gnt[i]) begin
        dst_cnt_d[i] = dst_cnt_q[i] + FCNT_W'(1);
      end else if (tail_gnt[i] && !push_ok[i]) begin
        dst_cnt_d[i] = dst_cnt_q[i] - FCNT_W'(1);
      end
    end
  end

  // VC FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < VC_N; i++) begin
        state_q[i] <= VC_IDLE;
      end
    end else begin
      for (int i = 0; i < VC_N; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // VC FSM next state
  always_comb begin
    for (int i = 0; i < VC_N; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        VC_IDLE: begin
          if (dst_cnt_d[i] != '0) begin
            state_d[i] = VC_ACTIVE;
          end
        end
        VC_ACTIVE: begin
          if (tail_gnt[i] && (dst_cnt_d[i] == '0)) begin
            state_d[i] = VC_IDLE;
          end
        end
        default: state_d[i] = VC_IDLE;
      endcase
    end
  end

  // VC FSM outputs: request and destination of the head packet
  always_comb begin
    in_vc_requests = '0;
    port_selects   = '0;
    for (int i = 0; i < VC_N; i++) begin
      if (state_q[i] == VC_ACTIVE) begin
        in_vc_requests[i]              = (occ_q[i] != '0) && (cred_q[i] != '0);
        port_selects[i*SEL_W +: SEL_W] = dst_q[i][dst_rd_q[i]];
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_out_q <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < VC_N; i++) begin
        occ_q[i]     <= '0;
        cred_q[i]    <= CNT_W'(BUF_DEPTH);
        tail_q[i]    <= '0;
        dst_rd_q[i]  <= '0;
        dst_wr_q[i]  <= '0;
        dst_cnt_q[i] <= '0;
        for (int k = 0; k < DST_FIFO_DEPTH; k++) begin
          dst_q[i][k] <= '0;
        end
      end
    end else begin
      credit_out_q <= credit_out_d;
      err_q        <= err_d;
      for (int i = 0; i < VC_N; i++) begin
        occ_q[i]     <= occ_d[i];
        cred_q[i]    <= cred_d[i];
        tail_q[i]    <= tail_d[i];
        dst_rd_q[i]  <= dst_rd_d[i];
        dst_wr_q[i]  <= dst_wr_d[i];
        dst_cnt_q[i] <= dst_cnt_d[i];
        for (int k = 0; k < DST_FIFO_DEPTH; k++) begin
          dst_q[i][k] <= dst_d[i][k];
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_req_gen.sv
// tb_sw_req_gen: directed-vector bench for sw_req_gen (4 VCs, 2-bit selects,
// 4-deep buffers, 2-deep destination FIFOs). Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_sw_req_gen;

  localparam int unsigned VC_N  = 4;
  localparam int unsigned SEL_W = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    wr_en;
  logic [VC_N-1:0]         wr_vc;
  logic                    wr_hdr;
  logic                    wr_tail;
  logic [SEL_W-1:0]        wr_port_sel;
  logic [VC_N-1:0]         credit_in;
  logic [VC_N-1:0]         in_vc_granted;
  logic [VC_N-1:0]         in_vc_requests;
  logic [VC_N*SEL_W-1:0]   port_selects;
  logic [VC_N-1:0]         rd_vc;
  logic [VC_N-1:0]         credit_out;
  logic                    err;

  int n_checks = 0;
  int n_fail   = 0;

  sw_req_gen #(
    .VC_NUM_PER_PORT    (4),
    .PORT_NUM           (5),
    .PORT_SEL_BCD_WIDTH (2),
    .BUF_DEPTH          (4),
    .DST_FIFO_DEPTH     (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_vc          (wr_vc),
    .wr_hdr         (wr_hdr),
    .wr_tail        (wr_tail),
    .wr_port_sel    (wr_port_sel),
    .credit_in      (credit_in),
    .in_vc_granted  (in_vc_granted),
    .in_vc_requests (in_vc_requests),
    .port_selects   (port_selects),
    .rd_vc          (rd_vc),
    .credit_out     (credit_out),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wr_en         = 1'b0;
    wr_vc         = '0;
    wr_hdr        = 1'b0;
    wr_tail       = 1'b0;
    wr_port_sel   = '0;
    credit_in     = '0;
    in_vc_granted = '0;
  endtask

  // Advance to just after the next rising edge and drop all inputs
  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wr(input int vc, input logic hdr, input logic tail, input int sel);
    wr_en       = 1'b1;
    wr_vc       = VC_N'(1 << vc);
    wr_hdr      = hdr;
    wr_tail     = tail;
    wr_port_sel = SEL_W'(sel);
    step();
  endtask

  task automatic gnt(input int vc, input logic [31:0] exp_rd, input string tag);
    in_vc_granted = VC_N'(1 << vc);
    mid();
    chk(tag, 32'(rd_vc), exp_rd);
    step();
  endtask

  task automatic cred(input int vc);
    credit_in = VC_N'(1 << vc);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin
    clr();
    reset = 1'b1;
    #2;
    chk("rst_req",  32'(in_vc_requests), 'h0);
    chk("rst_psel", 32'(port_selects),   'h0);
    chk("rst_rd",   32'(rd_vc),          'h0);
    chk("rst_cout", 32'(credit_out),     'h0);
    chk("rst_err",  32'(err),            'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 3-flit packet on VC1 to output 2
    wr(1, 1'b1, 1'b0, 2);
    wr(1, 1'b0, 1'b0, 0);
    wr(1, 1'b0, 1'b1, 0);
    mid();
    chk("t1_req",  32'(in_vc_requests), 'h2);
    chk("t1_psel", 32'(port_selects),   'h08);
    step();
    in_vc_granted = 4'b0010;
    mid();
    chk("t1_rd0",   32'(rd_vc),      'h2);
    chk("t1_cout0", 32'(credit_out), 'h0);
    step();
    for (int k = 1; k < 3; k++) begin
      in_vc_granted = 4'b0010;
      mid();
      chk("t1_rd",   32'(rd_vc),      'h2);
      chk("t1_cout", 32'(credit_out), 'h2);
      step();
    end
    mid();
    chk("t1_req_idle",  32'(in_vc_requests), 'h0);
    chk("t1_psel_idle", 32'(port_selects),   'h0);
    chk("t1_cout_last", 32'(credit_out),     'h2);
    step();
    mid();
    chk("t1_cout_off", 32'(credit_out), 'h0);
    step();
    repeat (3) cred(1);

    // Credit exhaustion on VC0
    for (int k = 0; k < 4; k++) begin
      wr(0, 1'b1, 1'b1, 1);
      mid();
      chk("t2_req", 32'(in_vc_requests), 'h1);
      step();
      gnt(0, 'h1, "t2_rd");
    end
    wr(0, 1'b1, 1'b1, 3);
    mid();
    chk("t2_req_nocred", 32'(in_vc_requests), 'h0);
    chk("t2_psel",       32'(port_selects),   'h03);
    step();
    credit_in = 4'b0001;
    mid();
    chk("t2_req_same", 32'(in_vc_requests), 'h0);
    step();
    mid();
    chk("t2_req_back", 32'(in_vc_requests), 'h1);
    step();
    gnt(0, 'h1, "t2_rd_last");
    repeat (4) cred(0);
    mid();
    chk("t2_err", 32'(err), 'h0);
    step();

    // Two queued destinations on VC2
    wr(2, 1'b1, 1'b0, 1);
    wr(2, 1'b0, 1'b1, 0);
    wr(2, 1'b1, 1'b1, 3);
    mid();
    chk("t3_req",  32'(in_vc_requests), 'h4);
    chk("t3_psel", 32'(port_selects),   'h10);
    step();
    gnt(2, 'h4, "t3_rd0");
    mid();
    chk("t3_psel_body", 32'(port_selects), 'h10);
    step();
    in_vc_granted = 4'b0100;
    mid();
    chk("t3_rd_tail",   32'(rd_vc),        'h4);
    chk("t3_psel_tail", 32'(port_selects), 'h10);
    step();
    mid();
    chk("t3_psel_next", 32'(port_selects),   'h30);
    chk("t3_req_next",  32'(in_vc_requests), 'h4);
    step();
    gnt(2, 'h4, "t3_rd2");
    mid();
    chk("t3_req_idle",  32'(in_vc_requests), 'h0);
    chk("t3_psel_idle", 32'(port_selects),   'h0);
    step();
    repeat (3) cred(2);

    // Simultaneous write+grant and credit+grant on VC3
    wr(3, 1'b1, 1'b0, 2);
    wr(3, 1'b0, 1'b0, 0);
    wr_en         = 1'b1;
    wr_vc         = 4'b1000;
    in_vc_granted = 4'b1000;
    mid();
    chk("t4_rd_wr", 32'(rd_vc), 'h8);
    step();
    gnt(3, 'h8, "t4_rd1");
    gnt(3, 'h8, "t4_rd2");
    mid();
    chk("t4_req_empty", 32'(in_vc_requests), 'h0);
    chk("t4_psel_hold", 32'(port_selects),   'h80);
    step();
    wr(3, 1'b0, 1'b1, 0);
    mid();
    chk("t4_req_tail", 32'(in_vc_requests), 'h8);
    step();
    in_vc_granted = 4'b1000;
    credit_in     = 4'b1000;
    mid();
    chk("t4_rd_cred", 32'(rd_vc), 'h8);
    step();
    mid();
    chk("t4_req_idle", 32'(in_vc_requests), 'h0);
    chk("t4_psel_idle", 32'(port_selects),  'h0);
    step();
    wr(3, 1'b1, 1'b1, 1);
    mid();
    chk("t4_req_cred1", 32'(in_vc_requests), 'h8);
    step();
    gnt(3, 'h8, "t4_rd4");
    wr(3, 1'b1, 1'b1, 1);
    mid();
    chk("t4_req_cred0", 32'(in_vc_requests), 'h0);
    chk("t4_psel_pend", 32'(port_selects),   'h40);
    step();
    repeat (4) cred(3);
    gnt(3, 'h8, "t4_rd5");
    cred(3);
    mid();
    chk("t4_err", 32'(err), 'h0);
    step();

    // Write to a full VC
    wr(0, 1'b1, 1'b0, 0);
    repeat (3) wr(0, 1'b0, 1'b0, 0);
    mid();
    chk("t5a_err_pre", 32'(err), 'h0);
    step();
    wr(0, 1'b0, 1'b0, 0);
    mid();
    chk("t5a_err_full", 32'(err), 'h1);
    step();
    repeat (3) gnt(0, 'h1, "t5a_rd");
    mid();
    chk("t5a_req_occ1", 32'(in_vc_requests), 'h1);
    step();
    gnt(0, 'h1, "t5a_rd4");
    cred(0);
    mid();
    chk("t5a_req_occ0", 32'(in_vc_requests), 'h0);
    chk("t5a_err_hold", 32'(err),            'h1);
    step();
    do_reset();

    // Third header into a two-entry destination FIFO
    wr(1, 1'b1, 1'b1, 1);
    wr(1, 1'b1, 1'b1, 2);
    mid();
    chk("t5b_err_pre", 32'(err), 'h0);
    step();
    wr(1, 1'b1, 1'b1, 3);
    mid();
    chk("t5b_err_fifo", 32'(err), 'h1);
    step();
    do_reset();

    // Grant to an idle VC
    in_vc_granted = 4'b0100;
    mid();
    chk("t5c_rd_idle", 32'(rd_vc), 'h0);
    chk("t5c_err_pre", 32'(err),   'h0);
    step();
    mid();
    chk("t5c_err_stray", 32'(err), 'h1);
    step();
    do_reset();

    // Credit returned while already at full count
    credit_in = 4'b0010;
    step();
    mid();
    chk("t5d_err_cred", 32'(err), 'h1);
    step();
    do_reset();

    // Multi-hot grant: lowest bit wins
    wr(0, 1'b1, 1'b1, 0);
    wr(1, 1'b1, 1'b1, 1);
    mid();
    chk("t5e_req", 32'(in_vc_requests), 'h3);
    step();
    in_vc_granted = 4'b0011;
    mid();
    chk("t5e_rd_low",  32'(rd_vc), 'h1);
    chk("t5e_err_pre", 32'(err),   'h0);
    step();
    mid();
    chk("t5e_err_multi", 32'(err),            'h1);
    chk("t5e_req_left",  32'(in_vc_requests), 'h2);
    step();
    repeat (3) step();
    mid();
    chk("t5e_err_sticky", 32'(err), 'h1);
    step();

    // Reset in the middle of a packet
    do_reset();
    wr(1, 1'b1, 1'b0, 2);
    wr(1, 1'b0, 1'b0, 0);
    in_vc_granted = 4'b0010;
    mid();
    chk("t6_rd", 32'(rd_vc), 'h2);
    step();
    chk("t6_cout_pre", 32'(credit_out), 'h2);
    reset = 1'b1;
    #1;
    chk("t6_req",  32'(in_vc_requests), 'h0);
    chk("t6_psel", 32'(port_selects),   'h0);
    chk("t6_rd0",  32'(rd_vc),          'h0);
    chk("t6_cout", 32'(credit_out),     'h0);
    chk("t6_err",  32'(err),            'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mid();
    chk("t6_req_after", 32'(in_vc_requests), 'h0);
    step();
    // Credits are back at full, so one more return is an overflow
    credit_in = 4'b0010;
    step();
    mid();
    chk("t6_cred_full", 32'(err), 'h1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
